// File: rtl/cart_loader_pkg.sv
// Shared types and helpers for the cartridge loader: FSM state encoding and
// the clamp that limits a requested byte count to the buffer depth.
package cart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_ACK  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  function automatic logic [16:0] len_clamp(input logic [15:0] size,
                                            input logic [16:0] depth);
    logic [16:0] w_size_ext;
    w_size_ext = {1'b0, size};
    if (w_size_ext > depth) begin
      return depth;
    end else begin
      return w_size_ext;
    end
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop level synchronizer for a single asynchronous control bit,
// cleared by the synchronous active-low reset.
module sync2 (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // metastability stage followed by the stable output stage
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/cart_loader.sv
// Copies a finished SPI download from the buffer into cartridge memory while
// holding the console in reset. Optional running checksum: CART_LOADER_CHECKSUM_EN.
module cart_loader
  import cart_loader_pkg::*;
#(
  parameter int                BUF_AW   = 13,
  parameter int                DST_AW   = 16,
  parameter logic [DST_AW-1:0] DST_BASE = 16'h2000,
  parameter int                RD_LAT   = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_downloading,
  input  logic [15:0]       i_size,
  output logic [BUF_AW-1:0] o_buf_a,
  input  logic [7:0]        i_buf_dout,
  output logic [DST_AW-1:0] o_mem_addr,
  output logic [7:0]        o_mem_data,
  output logic              o_mem_req,
  input  logic              i_mem_ack,
  output logic              o_cpu_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_trunc
`ifdef CART_LOADER_CHECKSUM_EN
  ,output logic [15:0]      o_csum
`endif
);

  localparam logic [16:0] DEPTH    = 17'(2 ** BUF_AW);
  localparam logic [1:0]  CNT_LAST = 2'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_state_step;
  state_t            w_state_nxt;
  logic              w_dl_s;
  logic              r_dl_d;
  logic              w_dl_rise;
  logic              w_dl_fall;
  logic              w_ack_ok;
  logic              w_last;
  logic [16:0]       w_len_c;
  logic              w_trunc_c;
  logic [16:0]       w_idx_inc;
  logic [DST_AW-1:0] w_addr_c;
  logic [16:0]       r_len;
  logic [16:0]       r_index;
  logic [1:0]        r_cnt;
  logic [BUF_AW-1:0] r_buf_a;
  logic [DST_AW-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              r_mem_req;
  logic              r_cpu_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_trunc;

  sync2 u_sync_dl (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_downloading),
    .o_q       (w_dl_s)
  );

  assign w_dl_rise = w_dl_s & ~r_dl_d;
  assign w_dl_fall = ~w_dl_s & r_dl_d;
  assign w_ack_ok  = i_mem_ack & r_mem_req;
  assign w_len_c   = len_clamp(i_size, DEPTH);
  assign w_trunc_c = ({1'b0, i_size} > DEPTH);
  assign w_idx_inc = r_index + 17'd1;
  assign w_last    = (w_idx_inc == r_len);
  assign w_addr_c  = DST_BASE + DST_AW'(r_index);

  // state register and edge-detect history
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_dl_d  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dl_d  <= w_dl_s;
    end
  end

  // next-state; a new download arriving mid-copy aborts back to idle
  always_comb begin
    w_state_step = r_state;
    w_state_nxt  = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_dl_fall) begin
          w_state_step = (w_len_c == 17'd0) ? ST_FIN : ST_RD;
        end else begin
          w_state_step = ST_IDLE;
        end
      end
      ST_RD: begin
        if (r_cnt == CNT_LAST) begin
          w_state_step = ST_WR;
        end else begin
          w_state_step = ST_RD;
        end
      end
      ST_WR:   w_state_step = ST_ACK;
      ST_ACK: begin
        if (w_ack_ok) begin
          w_state_step = w_last ? ST_FIN : ST_RD;
        end else begin
          w_state_step = ST_ACK;
        end
      end
      ST_FIN:  w_state_step = ST_IDLE;
      default: w_state_step = ST_IDLE;
    endcase
    if (w_dl_rise && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = w_state_step;
    end
  end

  // datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_len       <= 17'd0;
      r_index     <= 17'd0;
      r_cnt       <= 2'd0;
      r_buf_a     <= '0;
      r_mem_addr  <= DST_BASE;
      r_mem_data  <= 8'd0;
      r_mem_req   <= 1'b0;
      r_cpu_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_trunc     <= 1'b0;
    end else begin
      r_busy    <= (w_state_nxt == ST_RD) || (w_state_nxt == ST_WR) || (w_state_nxt == ST_ACK);
      r_done    <= (w_state_nxt == ST_FIN);
      r_mem_req <= (w_state_nxt == ST_ACK);
      if (w_dl_rise) begin
        r_cpu_reset <= 1'b1;
      end else if (w_state_nxt == ST_FIN) begin
        r_cpu_reset <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_dl_fall) begin
            r_len   <= w_len_c;
            r_trunc <= w_trunc_c;
            r_index <= 17'd0;
            r_buf_a <= '0;
            r_cnt   <= 2'd0;
          end
        end
        ST_RD:   r_cnt <= r_cnt + 2'd1;
        ST_WR: begin
          r_mem_data <= i_buf_dout;
          r_mem_addr <= w_addr_c;
        end
        ST_ACK: begin
          if (w_ack_ok) begin
            r_index <= w_idx_inc;
            r_buf_a <= w_idx_inc[BUF_AW-1:0];
            r_cnt   <= 2'd0;
          end
        end
        default: r_cnt <= 2'd0;
      endcase
    end
  end

  assign o_buf_a     = r_buf_a;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_data  = r_mem_data;
  assign o_mem_req   = r_mem_req;
  assign o_cpu_reset = r_cpu_reset;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_trunc     = r_trunc;

`ifdef CART_LOADER_CHECKSUM_EN
  logic [15:0] r_csum;

  // sum of accepted bytes, restarted when a new download completes
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_csum <= 16'd0;
    end else if (w_dl_fall) begin
      r_csum <= 16'd0;
    end else if (w_ack_ok) begin
      r_csum <= r_csum + {8'd0, r_mem_data};
    end
  end

  assign o_csum = r_csum;
`endif

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: buffer model with 2-cycle read latency,
// ack responder that records writes, and an expected-write queue.
module tb_cart_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        downloading = 1'b0;
  logic [15:0] size = 16'd0;
  logic [7:0]  buf_dout = 8'd0;
  logic        mem_ack = 1'b0;
  logic [12:0] buf_a;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_req, cpu_reset, busy, done, trunc;
`ifdef CART_LOADER_CHECKSUM_EN
  logic [15:0] csum;
`endif

  int checks = 0;
  int failures = 0;
  int writes = 0;
  int hold_viol = 0;
  int crst_viol = 0;
  bit rand_mode = 1'b0;
  int wait_cnt = 0;
  bit req_seen = 1'b0;
  logic [15:0] held_addr = 16'd0;
  logic [7:0]  held_data = 8'd0;
  logic [7:0]  rd_p1 = 8'd0;
  logic [7:0]  bufmem [0:8191];
  logic [23:0] sb [$];
  logic [23:0] obs [$];

  always #5 clk = ~clk;

  cart_loader dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_downloading (downloading),
    .i_size        (size),
    .o_buf_a       (buf_a),
    .i_buf_dout    (buf_dout),
    .o_mem_addr    (mem_addr),
    .o_mem_data    (mem_data),
    .o_mem_req     (mem_req),
    .i_mem_ack     (mem_ack),
    .o_cpu_reset   (cpu_reset),
    .o_busy        (busy),
    .o_done        (done),
    .o_trunc       (trunc)
`ifdef CART_LOADER_CHECKSUM_EN
    ,.o_csum       (csum)
`endif
  );

  // buffer: address registered, data two clocks later
  always @(posedge clk) begin
    rd_p1    <= bufmem[buf_a];
    buf_dout <= rd_p1;
  end

  // ack responder: records each acknowledged write and watches hold stability
  always @(negedge clk) begin
    if (busy && !cpu_reset) crst_viol++;
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (reset_n && mem_req) begin
      if (req_seen && (mem_addr !== held_addr || mem_data !== held_data)) hold_viol++;
      held_addr = mem_addr;
      held_data = mem_data;
      req_seen  = 1'b1;
      if (wait_cnt == 0) begin
        mem_ack  = 1'b1;
        req_seen = 1'b0;
        writes++;
        obs.push_back({mem_addr, mem_data});
        wait_cnt = rand_mode ? int'($urandom_range(0, 7)) : 0;
      end else begin
        wait_cnt--;
      end
    end else begin
      req_seen = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_buf_a"},     32'(buf_a),     32'h0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'h2000);
    check({tag, "_mem_data"},  32'(mem_data),  32'h0);
    check({tag, "_mem_req"},   32'(mem_req),   32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
    check({tag, "_done"},      32'(done),      32'h0);
    check({tag, "_trunc"},     32'(trunc),     32'h0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'h0);
  endtask

  task automatic fill(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      bufmem[i] = (mode == 0) ? 8'($urandom_range(0, 255)) : 8'(i * 7 + 3);
      sb.push_back({16'(16'h2000 + i), bufmem[i]});
    end
  endtask

  task automatic dl_start();
    @(negedge clk);
    downloading = 1'b1;
    size = 16'hDEAD;
    repeat (4) @(negedge clk);
    check("cpu_reset_on_rise", 32'(cpu_reset), 32'h1);
  endtask

  task automatic dl_end(input logic [15:0] sz);
    size = sz;
    downloading = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'h1);
    if (seen) begin
      check({tag, "_crst_at_done"}, 32'(cpu_reset), 32'h0);
      check({tag, "_busy_at_done"}, 32'(busy), 32'h0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done), 32'h0);
    end
  endtask

  // compare recorded writes against expectations in order
  task automatic drain(output int n, output logic [15:0] last);
    logic [23:0] o, e;
    n = 0;
    last = 16'h0;
    while (obs.size() != 0) begin
      o = obs.pop_front();
      e = (sb.size() != 0) ? sb.pop_front() : 24'hxxxxxx;
      check("wr_addr", 32'(o[23:8]), 32'(e[23:8]));
      check("wr_data", 32'(o[7:0]), 32'(e[7:0]));
      last = o[23:8];
      n++;
    end
  endtask

  initial begin
    int n, w0, hv0;
    bit hit;
    logic [15:0] last;

    // reset state
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;

    // basic copy
    bufmem[0] = 8'h11; bufmem[1] = 8'h22; bufmem[2] = 8'h33; bufmem[3] = 8'h44;
    for (int i = 0; i < 4; i++) sb.push_back({16'(16'h2000 + i), bufmem[i]});
    dl_start();
    dl_end(16'd4);
    wait_done("basic", 200);
    drain(n, last);
    check("basic_count", 32'(n), 32'd4);
    check("basic_last", 32'(last), 32'h2003);
    check("basic_sb_empty", 32'(sb.size()), 32'd0);
    check("basic_trunc", 32'(trunc), 32'h0);

    // zero length
    w0 = writes;
    dl_start();
    dl_end(16'd0);
    wait_done("zero", 6);
    check("zero_no_write", 32'(writes - w0), 32'd0);
    check("zero_trunc", 32'(trunc), 32'h0);

    // truncation to buffer depth
    fill(8192, 1);
    dl_start();
    dl_end(16'h3000);
    wait_done("trunc", 40000);
    drain(n, last);
    check("trunc_count", 32'(n), 32'd8192);
    check("trunc_last", 32'(last), 32'h3FFF);
    check("trunc_flag", 32'(trunc), 32'h1);
    check("trunc_sb_empty", 32'(sb.size()), 32'd0);

    // backpressure with random ack delays
    rand_mode = 1'b1;
    hv0 = hold_viol;
    fill(20, 0);
    dl_start();
    dl_end(16'd20);
    wait_done("bp", 2000);
    drain(n, last);
    check("bp_count", 32'(n), 32'd20);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);
    check("bp_hold_stable", 32'(hold_viol - hv0), 32'd0);
    check("bp_trunc_cleared", 32'(trunc), 32'h0);
    rand_mode = 1'b0;

    // abort by a new download after two writes
    fill(10, 0);
    dl_start();
    dl_end(16'd10);
    w0 = writes;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (writes >= w0 + 2) begin hit = 1'b1; break; end
    end
    check("abort_reach2", 32'(hit), 32'h1);
    downloading = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_req", 32'(mem_req), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_crst", 32'(cpu_reset), 32'h1);
    w0 = writes;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) hit = 1'b1;
    end
    check("abort_no_done", 32'(hit), 32'h0);
    check("abort_no_writes", 32'(writes - w0), 32'd0);
    drain(n, last);
    check("abort_partial", 32'(n >= 2 && n <= 3), 32'h1);
    sb.delete();
    fill(3, 0);
    dl_end(16'd3);
    wait_done("restart", 200);
    drain(n, last);
    check("restart_count", 32'(n), 32'd3);
    check("restart_last", 32'(last), 32'h2002);

    // synchronous reset mid-copy
    fill(10, 0);
    dl_start();
    dl_end(16'd10);
    w0 = writes;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (writes >= w0 + 2) begin hit = 1'b1; break; end
    end
    check("rst_reach2", 32'(hit), 32'h1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("midrst");
    reset_n = 1'b1;
    drain(n, last);
    sb.delete();

    // checksum bytes
    bufmem[0] = 8'hFF; bufmem[1] = 8'hFF; bufmem[2] = 8'h02;
    for (int i = 0; i < 3; i++) sb.push_back({16'(16'h2000 + i), bufmem[i]});
    dl_start();
    dl_end(16'd3);
    wait_done("csum_run", 200);
`ifdef CART_LOADER_CHECKSUM_EN
    check("csum", 32'(csum), 32'h0200);
`endif
    drain(n, last);
    check("csum_run_count", 32'(n), 32'd3);
    check("crst_held_while_busy", 32'(crst_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
